snoop_responder: RTL
====================

// Module: snoop_responder
// PURPOSE
//   Per-core snoop side of the SMP coherence bus: answers bus search/invalidate requests against this
//   core's direct-mapped data cache (MSI). One instance per cpu, between the bus arbiter's snoop outputs
//   and the cache tag/state/data arrays. Supplies dirty data on a hit-Modified, downgrades or invalidates
//   the line, and reports search_found back to the bus.
// PARAMETERS
//   ADDR_W   11  bus address width (word address)
//   INDEX_W  5   cache index bits; TAG_W = ADDR_W-INDEX_W = 6
//   DATA_W   16  cache word / bus data width
// PORTS
//   clk              in   1        system clock
//   rst_n            in   1        synchronous active-low reset
//   snoop_req        in   1        bus snoop request (4-phase, held until snoop_ack)
//   snoop_op         in   2        00 PROBE_RD, 01 PROBE_WR, 10 INVALIDATE, 11 reserved
//   addr_in          in   ADDR_W   snooped address, stable while snoop_req high
//   snoop_ack        out  1        response valid; held high until snoop_req drops
//   cpu_search_found out  1        line present (state != I, tag match); valid with snoop_ack
//   snoop_dirty      out  1        line was Modified and was written back; valid with snoop_ack
//   cpu_stall        out  1        blocks local cache accesses while snoop in progress
//   tag_idx          out  INDEX_W  index to tag/state/data arrays (1-cycle registered read)
//   tag_rd_tag       in   TAG_W    tag read data
//   tag_rd_state     in   2        MSI state read: 00 I, 01 S, 10 M
//   data_rdata       in   DATA_W   cache data word at tag_idx
//   state_we         out  1        1-cycle pulse: write state_wdata at tag_idx
//   state_wdata      out  2        new MSI state
//   wb_valid         out  1        writeback valid to bus/dmem
//   wb_addr          out  ADDR_W   writeback address (= latched addr_in)
//   wb_data          out  DATA_W   writeback data
//   wb_ready         in   1        bus/dmem accepts writeback this cycle
// BEHAVIOUR
//   Reset: FSM->IDLE; snoop_ack, cpu_search_found, snoop_dirty, state_we, wb_valid = 0; latched addr/op = 0.
//   Reset wins over everything, mid-transaction included: in-flight wb_valid dropped, no state write.
//   FSM: IDLE, LOOKUP, EVAL, WBACK, UPDATE, ACK.
//   IDLE: snoop_req=1 -> latch addr_in/snoop_op, tag_idx=addr[INDEX_W-1:0] -> LOOKUP.
//   LOOKUP: array read in flight -> EVAL.
//   EVAL: hit = tag_rd_state!=I && tag_rd_tag==addr[ADDR_W-1:INDEX_W]; register hit into found.
//     miss or op==11 -> ACK (found=0 for op 11, no state change).
//     hit, state M -> WBACK (capture data_rdata into wb_data, dirty=1).
//     hit, state S: PROBE_RD -> ACK (no write); PROBE_WR/INVALIDATE -> UPDATE.
//   WBACK: wb_valid=1, wb_addr/wb_data stable; transfer when wb_valid&&wb_ready -> UPDATE next cycle.
//   UPDATE: state_we=1 one cycle; PROBE_RD: M->S; PROBE_WR/INVALIDATE: ->I. -> ACK.
//   ACK: snoop_ack=1 with found/dirty stable; stay until snoop_req=0, then -> IDLE (ack drops same edge).
//     A new snoop_req is accepted only from IDLE; back-to-back needs one low cycle of snoop_req.
//   INVALIDATE on M line: treated as protocol-safe, written back before invalidation.
//   Latency (req sampled in IDLE at cycle 0): miss/hit-S-read ack at cycle 3; hit-S-write 4;
//     hit-M with wb_ready already high 5; each wb_ready-low cycle adds one.
//   cpu_stall = (state!=IDLE) | snoop_req (combinational), so local access never races the snoop.
//   Only one snoop outstanding; snoop_op/addr_in changes during a transaction are ignored.
// STRUCTURE
//   smp_pkg: blk_state_t enum {I=2'b00,S=2'b01,M=2'b10}, snoop_op_t enum {PROBE_RD,PROBE_WR,
//     INVALIDATE,OP_RSVD}, ADDR_W/INDEX_W/DATA_W defaults; shared with bus and cache.
//   Single module, one FSM; no sub-module. Arrays live in the cache, accessed via tag_idx port.
// TESTING
//   T1 miss: line 5 = I, PROBE_RD addr 0x085 -> ack at cycle 3, found=0, dirty=0, no state_we, no wb_valid.
//   T2 hit S read: idx 5 tag 0x04 S, PROBE_RD 0x085 -> ack cycle 3, found=1, dirty=0, state stays S.
//   T3 hit M read: idx 5 tag 0x04 M data 0xBEEF, wb_ready=1 -> wb 0x085/0xBEEF once, state_we S, ack cycle 5, dirty=1.
//   T4 hit M, PROBE_WR, wb_ready low 3 cycles -> wb_valid held 4 cycles, data stable, state->I, ack cycle 8.
//   T5 tag mismatch: idx 5 tag 0x03 M, INVALIDATE 0x085 -> found=0, no wb, state stays M; op 11 -> found=0.
//   T6 rst_n low during WBACK -> next cycle wb_valid=0, ack=0, IDLE, no state_we; new req after reset served.

Source files
------------

// File: rtl/smp_pkg.sv
// Shared SMP coherence definitions: MSI line states, snoop opcodes and bus geometry.
package smp_pkg;

  localparam int ADDR_W_DEF  = 11;
  localparam int INDEX_W_DEF = 5;
  localparam int DATA_W_DEF  = 16;

  typedef enum logic [1:0] {
    I = 2'b00,
    S = 2'b01,
    M = 2'b10
  } blk_state_t;

  typedef enum logic [1:0] {
    PROBE_RD   = 2'b00,
    PROBE_WR   = 2'b01,
    INVALIDATE = 2'b10,
    OP_RSVD    = 2'b11
  } snoop_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_EVAL,
    ST_WBACK,
    ST_UPDATE,
    ST_ACK
  } snoop_fsm_t;

endpackage

// File: rtl/snoop_responder.sv
// Per-core snoop responder: looks up a snooped address in the local MSI cache,
// writes back Modified data, downgrades/invalidates the line and acknowledges the bus.
module snoop_responder
  import smp_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    snoop_req,
  input  logic [1:0]              snoop_op,
  input  logic [ADDR_W-1:0]       addr_in,
  output logic                    snoop_ack,
  output logic                    cpu_search_found,
  output logic                    snoop_dirty,
  output logic                    cpu_stall,
  output logic [INDEX_W-1:0]      tag_idx,
  input  logic [ADDR_W-INDEX_W-1:0] tag_rd_tag,
  input  logic [1:0]              tag_rd_state,
  input  logic [DATA_W-1:0]       data_rdata,
  output logic                    state_we,
  output logic [1:0]              state_wdata,
  output logic                    wb_valid,
  output logic [ADDR_W-1:0]       wb_addr,
  output logic [DATA_W-1:0]       wb_data,
  input  logic                    wb_ready
);

  localparam int TAG_W = ADDR_W - INDEX_W;

  snoop_fsm_t        state_q;
  snoop_op_t         op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wb_data_q;
  blk_state_t        state_wdata_q;
  logic              ack_q;
  logic              found_q;
  logic              dirty_q;
  logic              state_we_q;
  logic              wb_valid_q;
  logic              hit;
  logic              rd_is_m;

  // Array read data is only meaningful in EVAL, one cycle after tag_idx settled in LOOKUP.
  assign hit     = (tag_rd_state != 2'(I)) && (tag_rd_tag == addr_q[ADDR_W-1:INDEX_W]);
  assign rd_is_m = (tag_rd_state == 2'(M));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= PROBE_RD;
      addr_q        <= '0;
      wb_data_q     <= '0;
      state_wdata_q <= I;
      ack_q         <= 1'b0;
      found_q       <= 1'b0;
      dirty_q       <= 1'b0;
      state_we_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
    end else begin
      state_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (snoop_req) begin
            addr_q  <= addr_in;
            op_q    <= snoop_op_t'(snoop_op);
            found_q <= 1'b0;
            dirty_q <= 1'b0;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: state_q <= ST_EVAL;
        ST_EVAL: begin
          found_q <= hit && (op_q != OP_RSVD);
          if (!hit || op_q == OP_RSVD) begin
            ack_q   <= 1'b1;
            state_q <= ST_ACK;
          end else if (rd_is_m) begin
            // Invalidate of a Modified line also writes back so no dirty data is lost.
            wb_data_q  <= data_rdata;
            dirty_q    <= 1'b1;
            wb_valid_q <= 1'b1;
            state_q    <= ST_WBACK;
          end else if (op_q == PROBE_RD) begin
            ack_q   <= 1'b1;
            state_q <= ST_ACK;
          end else begin
            state_we_q    <= 1'b1;
            state_wdata_q <= I;
            state_q       <= ST_UPDATE;
          end
        end
        ST_WBACK: begin
          if (wb_ready) begin
            wb_valid_q    <= 1'b0;
            state_we_q    <= 1'b1;
            state_wdata_q <= (op_q == PROBE_RD) ? S : I;
            state_q       <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          ack_q   <= 1'b1;
          state_q <= ST_ACK;
        end
        ST_ACK: begin
          if (!snoop_req) begin
            ack_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign snoop_ack        = ack_q;
  assign cpu_search_found = found_q;
  assign snoop_dirty      = dirty_q;
  assign cpu_stall        = (state_q != ST_IDLE) | snoop_req;
  assign tag_idx          = addr_q[INDEX_W-1:0];
  assign state_we         = state_we_q;
  assign state_wdata      = state_wdata_q;
  assign wb_valid         = wb_valid_q;
  assign wb_addr          = addr_q;
  assign wb_data          = wb_data_q;

  logic unused_tagw;
  assign unused_tagw = (TAG_W == 0);

endmodule
